// File: rtl/mem_req_if.sv
`timescale 1ns/1ps
// Data-bus handshake between the memory request engine and the data memory.
// req is held until addr_ok; data_ok answers the oldest accepted request.
interface mem_req_if #(
   parameter int ADDR_W = 32
) ();
   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [31:0]       data_wdata;
   logic [3:0]        data_wstrb;
   logic              data_addr_ok;
   logic [31:0]       data_rdata;
   logic              data_data_ok;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      input  data_addr_ok, data_rdata, data_data_ok
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      output data_addr_ok, data_rdata, data_data_ok
   );
endinterface

// File: rtl/mem_req_unit.sv
`timescale 1ns/1ps
// Memory-stage request engine: issues load/store requests on the data bus,
// tracks up to DEPTH outstanding transactions in order, and aligns/extends
// load data for write-back.
module mem_req_unit #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_load,
   input  logic              in_store,
   input  logic [1:0]        in_size,
   input  logic              in_sign,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [31:0]       in_wdata,
   input  logic [4:0]        in_rd,
   input  logic              exception,
   mem_req_if.master         bus,
   output logic              out_valid,
   output logic              out_is_load,
   output logic [4:0]        out_rd,
   output logic [31:0]       out_rdata,
   output logic              addr_err,
   output logic              resp_err
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] REQ  = 1'b1;

   typedef struct packed {
      logic       is_load;
      logic [1:0] size;
      logic       sign;
      logic [1:0] off;
      logic [4:0] rd;
   } entry_t;

   logic [0:0]        state;
   logic              r_wr;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_wstrb;
   entry_t            r_ent;

   entry_t            fifo [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   entry_t            head;

   logic [1:0]  size_n;
   logic        misalign, accept, take, push, pop;
   logic [31:0] fmt_wdata, ld_data;
   logic [3:0]  fmt_wstrb;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // size 3 behaves as a word everywhere downstream
   assign size_n   = (in_size == 2'd3) ? 2'd2 : in_size;
   assign misalign = ((size_n == 2'd1) && in_addr[0]) ||
                     ((size_n == 2'd2) && (in_addr[1:0] != 2'b00));
   assign in_ready = (state == IDLE) && (count < DEPTH_C);
   assign accept   = in_valid && in_ready;
   assign take     = accept && !exception && !misalign;
   assign push     = (state == REQ) && bus.data_addr_ok;
   assign pop      = bus.data_data_ok && (count != '0);
   assign head     = fifo[rd_ptr];

   assign bus.data_req   = (state == REQ);
   assign bus.data_wr    = r_wr;
   assign bus.data_size  = r_size;
   assign bus.data_addr  = r_addr;
   assign bus.data_wdata = r_wdata;
   assign bus.data_wstrb = r_wstrb;

   // replicate store data across lanes and build byte enables
   always_comb begin
      fmt_wdata = in_wdata;
      fmt_wstrb = 4'b1111;
      case (size_n)
         2'd0: begin
            fmt_wdata = {4{in_wdata[7:0]}};
            fmt_wstrb = 4'b0001 << in_addr[1:0];
         end
         2'd1: begin
            fmt_wdata = {2{in_wdata[15:0]}};
            fmt_wstrb = in_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
      if (!in_store) fmt_wstrb = 4'b0000;
   end

   // capture an accepted request and hold it until the bus takes it
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         r_wr    <= 1'b0;
         r_size  <= 2'd0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= 4'b0000;
         r_ent   <= '0;
      end else if (take) begin
         state   <= REQ;
         r_wr    <= in_store;
         r_size  <= size_n;
         r_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
         r_wdata <= fmt_wdata;
         r_wstrb <= fmt_wstrb;
         r_ent   <= '{is_load: in_load, size: size_n, sign: in_sign,
                      off: in_addr[1:0], rd: in_rd};
      end else if (push) begin
         state   <= IDLE;
      end
   end

   // tracking storage; only the entries between the pointers are meaningful
   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= r_ent;
   end

   // in-order pointers and occupancy
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // select and extend the loaded lane for the head transaction
   always_comb begin
      case (head.off)
         2'd0:    ld_byte = bus.data_rdata[7:0];
         2'd1:    ld_byte = bus.data_rdata[15:8];
         2'd2:    ld_byte = bus.data_rdata[23:16];
         default: ld_byte = bus.data_rdata[31:24];
      endcase
      ld_half = head.off[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
      case (head.size)
         2'd0:    ld_data = {{24{head.sign & ld_byte[7]}}, ld_byte};
         2'd1:    ld_data = {{16{head.sign & ld_half[15]}}, ld_half};
         default: ld_data = bus.data_rdata;
      endcase
   end

   // registered completion and error pulses
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid   <= 1'b0;
         out_is_load <= 1'b0;
         out_rd      <= 5'd0;
         out_rdata   <= '0;
         addr_err    <= 1'b0;
         resp_err    <= 1'b0;
      end else begin
         out_valid   <= pop;
         out_is_load <= pop && head.is_load;
         addr_err    <= accept && !exception && misalign;
         resp_err    <= bus.data_data_ok && (count == '0);
         if (pop) begin
            out_rd    <= head.rd;
            out_rdata <= head.is_load ? ld_data : 32'd0;
         end
      end
   end
endmodule

// File: tb/tb_mem_req_unit.sv
`timescale 1ns/1ps
// Bench for mem_req_unit: vector table of single transactions, scoreboard
// for completions, and hand-written sequences for stalls and corner cases.
module tb_mem_req_unit;
   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid, in_ready, in_load, in_store, in_sign, exception;
   logic [1:0]  in_size;
   logic [31:0] in_addr, in_wdata;
   logic [4:0]  in_rd;
   logic        out_valid, out_is_load, addr_err, resp_err;
   logic [4:0]  out_rd;
   logic [31:0] out_rdata;

   int passed = 0;
   int total  = 0;

   mem_req_if #(.ADDR_W(32)) bus ();

   mem_req_unit #(.ADDR_W(32), .DEPTH(2)) dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_load(in_load), .in_store(in_store), .in_size(in_size),
      .in_sign(in_sign), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_rd(in_rd), .exception(exception),
      .bus(bus),
      .out_valid(out_valid), .out_is_load(out_is_load), .out_rd(out_rd),
      .out_rdata(out_rdata), .addr_err(addr_err), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_load;
      logic [4:0]  rd;
      logic [31:0] rdata;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        load;
      logic [1:0]  size;
      logic        sign;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] e_addr;
      logic [1:0]  e_size;
      logic [31:0] e_wdata;
      logic [3:0]  e_wstrb;
      logic [31:0] e_rdata;
   } vec_t;
   vec_t vec [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic ld, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
      in_valid = 1'b1; in_load = ld; in_store = ~ld; in_size = sz;
      in_sign = sg; in_addr = a; in_wdata = wd; in_rd = rd;
   endtask

   // scoreboard: every completion pulse must match the oldest expectation
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (sb.size() == 0) chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_is_load", {31'd0, out_is_load}, {31'd0, e.is_load});
            chk("out_rdata", out_rdata, e.rdata);
            if (e.is_load) chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //        load sz sg addr          wdata         rdata         e_addr        esz e_wdata       strb     e_rdata
      vec[0] = '{1, 2, 0, 32'h0000_0100, 32'h0,        32'h8899_AABB, 32'h0000_0100, 2, 32'h0,        4'b0000, 32'h8899_AABB};
      vec[1] = '{1, 0, 1, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 32'h0000_0100, 0, 32'h0,        4'b0000, 32'hFFFF_FF80};
      vec[2] = '{1, 0, 0, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 32'h0000_0100, 0, 32'h0,        4'b0000, 32'h0000_0080};
      vec[3] = '{1, 1, 1, 32'h0000_0102, 32'h0,        32'h8001_0000, 32'h0000_0100, 1, 32'h0,        4'b0000, 32'hFFFF_8001};
      vec[4] = '{1, 1, 0, 32'h0000_0100, 32'h0,        32'h1234_F00D, 32'h0000_0100, 1, 32'h0,        4'b0000, 32'h0000_F00D};
      vec[5] = '{1, 0, 1, 32'h0000_0101, 32'h0,        32'h0000_7F00, 32'h0000_0100, 0, 32'h0,        4'b0000, 32'h0000_007F};
      vec[6] = '{0, 0, 0, 32'h0000_0201, 32'h0000_005A, 32'h0,        32'h0000_0200, 0, 32'h5A5A_5A5A, 4'b0010, 32'h0};
      vec[7] = '{0, 1, 0, 32'h0000_0302, 32'h1234_BEEF, 32'h0,        32'h0000_0300, 1, 32'hBEEF_BEEF, 4'b1100, 32'h0};
      vec[8] = '{0, 2, 0, 32'h0000_0404, 32'hDEAD_BEEF, 32'h0,        32'h0000_0404, 2, 32'hDEAD_BEEF, 4'b1111, 32'h0};
      vec[9] = '{1, 3, 0, 32'h0000_0108, 32'h0,        32'h1122_3344, 32'h0000_0108, 2, 32'h0,        4'b0000, 32'h1122_3344};

      resetn = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
      in_size = 2'd0; in_sign = 1'b0; in_addr = '0; in_wdata = '0; in_rd = '0;
      exception = 1'b0;
      bus.data_addr_ok = 1'b0; bus.data_rdata = '0; bus.data_data_ok = 1'b0;
      tick(); tick();
      chk("rst_data_req", {31'd0, bus.data_req}, 32'd0);
      chk("rst_data_addr", bus.data_addr, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_rdata", out_rdata, 32'd0);
      resetn = 1'b1;
      tick();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_errs", {30'd0, addr_err, resp_err}, 32'd0);
      chk("rst_wstrb", {28'd0, bus.data_wstrb}, 32'd0);

      // single transactions from the table
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
         offer(vec[i].load, vec[i].size, vec[i].sign, vec[i].addr, vec[i].wdata, 5'(i + 1));
         tick();
         in_valid = 1'b0;
         chk($sformatf("v%0d_req", i), {31'd0, bus.data_req}, 32'd1);
         chk($sformatf("v%0d_addr", i), bus.data_addr, vec[i].e_addr);
         chk($sformatf("v%0d_size", i), {30'd0, bus.data_size}, {30'd0, vec[i].e_size});
         chk($sformatf("v%0d_wr", i), {31'd0, bus.data_wr}, {31'd0, ~vec[i].load});
         chk($sformatf("v%0d_wstrb", i), {28'd0, bus.data_wstrb}, {28'd0, vec[i].e_wstrb});
         if (!vec[i].load) chk($sformatf("v%0d_wdata", i), bus.data_wdata, vec[i].e_wdata);
         bus.data_addr_ok = 1'b1;
         tick();
         bus.data_addr_ok = 1'b0;
         chk($sformatf("v%0d_ready_back", i), {31'd0, in_ready}, 32'd1);
         chk($sformatf("v%0d_req_drop", i), {31'd0, bus.data_req}, 32'd0);
         tick();
         bus.data_data_ok = 1'b1; bus.data_rdata = vec[i].rdata;
         sb.push_back('{vec[i].load, 5'(i + 1), vec[i].e_rdata});
         tick();
         bus.data_data_ok = 1'b0; bus.data_rdata = 32'hDEAD_0000;
         tick();
         chk($sformatf("v%0d_pulse_end", i), {31'd0, out_valid}, 32'd0);
      end

      // stalled handshake, then fill to DEPTH and drain
      offer(1'b1, 2'd2, 1'b0, 32'h0000_0500, 32'h0, 5'd7);
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("stall%0d_req", k), {31'd0, bus.data_req}, 32'd1);
         chk($sformatf("stall%0d_addr", k), bus.data_addr, 32'h0000_0500);
         chk($sformatf("stall%0d_size", k), {30'd0, bus.data_size}, 32'd2);
         chk($sformatf("stall%0d_ready", k), {31'd0, in_ready}, 32'd0);
         tick();
      end
      bus.data_addr_ok = 1'b1;
      tick();
      bus.data_addr_ok = 1'b0;
      chk("fill1_ready", {31'd0, in_ready}, 32'd1);
      offer(1'b1, 2'd2, 1'b0, 32'h0000_0504, 32'h0, 5'd8);
      tick();
      in_valid = 1'b0;
      bus.data_addr_ok = 1'b1;
      tick();
      bus.data_addr_ok = 1'b0;
      chk("full_ready_a", {31'd0, in_ready}, 32'd0);
      tick();
      chk("full_ready_b", {31'd0, in_ready}, 32'd0);
      bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1111_1111;
      sb.push_back('{1'b1, 5'd7, 32'h1111_1111});
      tick();
      bus.data_data_ok = 1'b0;
      chk("drain_ready", {31'd0, in_ready}, 32'd1);
      bus.data_data_ok = 1'b1; bus.data_rdata = 32'h2222_2222;
      sb.push_back('{1'b1, 5'd8, 32'h2222_2222});
      tick();
      bus.data_data_ok = 1'b0;
      tick(); tick();

      // misaligned word load and half store are dropped with addr_err
      offer(1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'h0, 5'd3);
      tick();
      in_valid = 1'b0;
      chk("mis_w_req", {31'd0, bus.data_req}, 32'd0);
      chk("mis_w_err", {31'd0, addr_err}, 32'd1);
      tick();
      chk("mis_w_err_end", {31'd0, addr_err}, 32'd0);
      offer(1'b0, 2'd1, 1'b0, 32'h0000_0201, 32'h1234, 5'd3);
      tick();
      in_valid = 1'b0;
      chk("mis_h_req", {31'd0, bus.data_req}, 32'd0);
      chk("mis_h_err", {31'd0, addr_err}, 32'd1);
      tick();

      // exception squashes aligned and misaligned ops without flags
      offer(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 5'd4);
      exception = 1'b1;
      tick();
      in_valid = 1'b0; exception = 1'b0;
      chk("exc_req", {31'd0, bus.data_req}, 32'd0);
      chk("exc_err", {31'd0, addr_err}, 32'd0);
      chk("exc_ready", {31'd0, in_ready}, 32'd1);
      offer(1'b1, 2'd2, 1'b0, 32'h0000_0103, 32'h0, 5'd4);
      exception = 1'b1;
      tick();
      in_valid = 1'b0; exception = 1'b0;
      chk("exc_mis_err", {31'd0, addr_err}, 32'd0);
      chk("exc_mis_req", {31'd0, bus.data_req}, 32'd0);

      // data_ok with nothing outstanding
      bus.data_data_ok = 1'b1;
      tick();
      bus.data_data_ok = 1'b0;
      chk("orphan_resp_err", {31'd0, resp_err}, 32'd1);
      chk("orphan_out_valid", {31'd0, out_valid}, 32'd0);
      tick();
      chk("orphan_resp_end", {31'd0, resp_err}, 32'd0);

      // reset while a request is pending
      offer(1'b0, 2'd2, 1'b0, 32'h0000_0600, 32'hCAFE_F00D, 5'd9);
      tick();
      in_valid = 1'b0;
      chk("rq_req", {31'd0, bus.data_req}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("rq_req_async", {31'd0, bus.data_req}, 32'd0);
      chk("rq_addr_async", bus.data_addr, 32'd0);
      tick();
      resetn = 1'b1;
      tick();
      chk("rq_ready", {31'd0, in_ready}, 32'd1);
      bus.data_data_ok = 1'b1;
      tick();
      bus.data_data_ok = 1'b0;
      chk("rq_resp_err", {31'd0, resp_err}, 32'd1);
      tick(); tick();

      chk("sb_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/mem_req_unit.md
# mem_req_unit

Parametrised memory-stage request engine replacing the single-cycle data-RAM driver. It accepts load/store operations from the execute stage and issues them on a req/addr_ok/data_ok data bus, holding each request until the bus accepts it. It tracks up to DEPTH outstanding transactions in order, then aligns and sign/zero-extends load data for write-back. Exception squash and misalignment detection are handled here, before any bus request is issued.

## Interface
- ADDR_W, 32, address width
- DEPTH, 2, max outstanding accepted-but-unanswered transactions (power of 2, ≥2)
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered by execute stage
- in_ready  out  1  unit can accept an operation this cycle
- in_load / in_store  in  1 / 1  operation type (exactly one high when in_valid)
- in_size  in  2  0 byte, 1 half, 2 word (3 treated as word)
- in_sign  in  1  loads: sign-extend when 1
- in_addr  in  ADDR_W  byte address
- in_wdata  in  32  store data, LSB-aligned
- in_rd  in  5  load destination register
- exception  in  1  squash the operation offered this cycle
- data_req  out  1  bus request, held until data_addr_ok
- data_wr  out  1  1 = write
- data_size  out  2  log2 bytes
- data_addr  out  ADDR_W  {in_addr[ADDR_W-1:2], 2'b00}
- data_wdata  out  32  lane-replicated store data
- data_wstrb  out  4  byte enables
- data_addr_ok  in  1  request accepted
- data_rdata  in  32  read data, valid with data_ok
- data_data_ok  in  1  response for oldest outstanding transaction
- out_valid  out  1  one-cycle completion pulse
- out_is_load  out  1  completion is a load
- out_rd  out  5  load destination
- out_rdata  out  32  aligned, extended load data (0 for stores)
- addr_err  out  1  one-cycle pulse: misaligned operation dropped
- resp_err  out  1  one-cycle pulse: data_ok with nothing outstanding

## Operation
- States: IDLE, REQ. in_ready = (state==IDLE) && (count<DEPTH).
- Accept = in_valid && in_ready. On accept:
  - If exception is high, the operation is dropped: no state change, no flag.
  - If misaligned (half with addr[0]=1; word with addr[1:0]≠0), the operation is dropped and addr_err pulses next cycle.
  - Otherwise the request registers are captured and the state goes to REQ.
- REQ: data_req=1 with stable fields. When data_addr_ok=1, push {is_load, size, sign, addr[1:0], rd} into the in-order tracking FIFO, count+1, and return to IDLE. Exception does not cancel a request already in REQ.
- Store formatting:
  - byte: wdata={4{b}}, wstrb=1<<off
  - half: wdata={2{h}}, wstrb=off[1]?1100:0011
  - word: wstrb=1111
  - data_wstrb=0 for loads; data_wr=is_store.
- data_data_ok with count>0: pop the head entry and count−1. Output is registered: out_valid, out_is_load and out_rd follow. Loads select the byte/half at the head offset from data_rdata and extend it per sign; stores give out_rdata=0.
- data_data_ok with count==0: ignored, resp_err pulses next cycle.
- Push and pop in the same cycle leave count unchanged. FIFO pointers wrap modulo DEPTH.

## Timing
- Reset (async assert, synchronous release): state IDLE, count 0, FIFO pointers 0. data_req, data_wr, data_wstrb, out_valid, out_is_load, addr_err and resp_err are 0. data_addr, data_wdata, data_size, out_rd and out_rdata are 0. in_ready is 1 from the first cycle after release.
- Accept at cycle T gives data_req=1 at T+1. With data_addr_ok at T+1, in_ready=1 again at T+2, so peak issue rate is one request per 2 cycles.
- data_data_ok for a transaction arrives no earlier than the cycle after its addr_ok. data_ok at cycle N gives out_valid at N+1 for exactly one cycle; there is no backpressure on the out_* signals.
- count==DEPTH: in_ready=0 until a data_ok arrives. A data_ok at cycle N makes in_ready=1 at N+1.
- Reset mid-transaction discards all outstanding state. Responses arriving afterwards raise resp_err.

## Test plan
- Word load at 0x100, sign=0: data_req at T+1 with addr 0x100, size 2, wr 0. Assert addr_ok at T+1 and data_ok at T+3 with rdata 0x8899AABB. Expect out_valid at T+4, out_rdata=0x8899AABB, out_rd echoed.
- Signed byte load at 0x103, rdata 0x80FF_FF7F: expect out_rdata=0xFFFFFF80. The same load with sign=0 gives 0x00000080. A signed half load at 0x102 with rdata 0x8001_0000 gives 0xFFFF8001.
- Byte store 0x5A at 0x201: expect data_wdata=0x5A5A5A5A, wstrb=0010, data_addr=0x200, wr=1. The store's data_ok gives out_valid=1, out_is_load=0.
- Hold addr_ok low 3 cycles: data_req and all fields stay stable. With DEPTH=2, after two handshakes without data_ok, in_ready=0. One data_ok restores in_ready the next cycle.
- Word load at 0x102 → addr_err pulse, no data_req. Any op offered with exception=1 → no data_req, no flags.
- data_ok with nothing outstanding → resp_err pulse, out_valid stays 0. Reset asserted while in REQ → data_req=0 immediately.
